// File: rtl/fip_32_cramer_div.sv
// fip_32_cramer_div -- Cramer's-rule quotient stage of a ray/triangle test.
// Takes det, det_t, det_u, det_v from the 3x3 determinant stage and produces
// t = det_t/det, u = det_u/det, v = det_v/det in signed Q(32-FRA_BITS).FRA_BITS,
// plus the hit flag. A single radix-2 restoring divider is shared by all three
// quotients and retires one quotient bit per cycle.
// Build option: define FIP_CRAMER_SAT_EN to clamp out-of-range quotients to the
// 32-bit signed limits; otherwise the quotient is truncated to its low 32 bits.
module fip_32_cramer_div #(
   parameter int FRA_BITS = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_det,
   input  logic [31:0] i_det_t,
   input  logic [31:0] i_det_u,
   input  logic [31:0] i_det_v,
   output logic [31:0] o_t,
   output logic [31:0] o_u,
   output logic [31:0] o_v,
   output logic        o_hit,
   output logic        o_valid,
   input  logic        i_ready
);

   localparam int W  = 32 + FRA_BITS;
   localparam int CW = $clog2(W);
   localparam logic [CW-1:0]     LAST_BIT = CW'(W - 1);
   localparam logic signed [32:0] ONE_Q   = 33'(1) << FRA_BITS;

   typedef enum logic [1:0] {IDLE, DIV, CHK, DONE} state_t;
   state_t state_reg, state_next;

   logic [31:0]   det_reg;
   logic [31:0]   num_reg [3];
   logic [1:0]    idx_reg;
   logic [CW-1:0] bit_cnt_reg;
   logic [W-1:0]  rem_reg;
   logic [W-1:0]  dvd_reg;
   logic [W-2:0]  quo_reg;

   logic          accept;
   logic          bit_last;
   logic          div_last;
   logic [W-1:0]  divisor;
   logic [W:0]    rem_sh;
   logic          ge;
   logic [W-1:0]  rem_nx;
   logic [W-1:0]  quo_nx;
   logic [31:0]   cur_num;
   logic [31:0]   nxt_num;
   logic          neg;
   logic [W-1:0]  q_sgn;
   logic [31:0]   q_fin;
   logic [2:0][31:0] q_all;
   logic          hit;

   function automatic logic [31:0] abs32(input logic [31:0] x);
      return x[31] ? (~x + 32'd1) : x;
   endfunction

   // Dividend for one quotient: |num| scaled up by the fractional width.
   function automatic logic [W-1:0] mag_shift(input logic [31:0] x);
      return {abs32(x), {FRA_BITS{1'b0}}};
   endfunction

   assign accept   = i_valid && (state_reg == IDLE);
   assign bit_last = (bit_cnt_reg == LAST_BIT);
   assign div_last = bit_last && (idx_reg == 2'd2);
   assign o_ready  = (state_reg == IDLE);
   assign o_valid  = (state_reg == DONE);
   assign divisor  = {{FRA_BITS{1'b0}}, abs32(det_reg)};

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Next-state logic: a zero determinant skips the divider entirely.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (accept) state_next = (i_det != 32'd0) ? DIV : CHK;
         DIV:  if (div_last) state_next = CHK;
         CHK:  state_next = DONE;
         DONE: if (i_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // One restoring-division step plus sign fix-up of the finished quotient.
   always_comb begin
      rem_sh  = {rem_reg, dvd_reg[W-1]};
      ge      = (rem_sh >= {1'b0, divisor});
      // When ge is set the true difference is below the divisor, so W bits suffice.
      rem_nx  = ge ? (rem_sh[W-1:0] - divisor) : rem_sh[W-1:0];
      quo_nx  = {quo_reg, ge};
      case (idx_reg)
         2'd0:    cur_num = num_reg[0];
         2'd1:    cur_num = num_reg[1];
         default: cur_num = num_reg[2];
      endcase
      nxt_num = (idx_reg == 2'd0) ? num_reg[1] : num_reg[2];
      neg     = cur_num[31] ^ det_reg[31];
      q_sgn   = neg ? (~quo_nx + W'(1)) : quo_nx;
   end

`ifdef FIP_CRAMER_SAT_EN
   // Clamp when the upper bits are not a pure sign extension of bit 31.
   always_comb begin
      if (q_sgn[W-1:31] == {(W-31){q_sgn[W-1]}})
         q_fin = q_sgn[31:0];
      else
         q_fin = q_sgn[W-1] ? 32'h8000_0000 : 32'h7fff_ffff;
   end
`else
   logic [W-33:0] unused_q_hi;
   assign unused_q_hi = q_sgn[W-1:32];
   assign q_fin       = q_sgn[31:0];
`endif

   // Divider datapath: load operands on accept, then shift/subtract in DIV.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         det_reg     <= '0;
         num_reg[0]  <= '0;
         num_reg[1]  <= '0;
         num_reg[2]  <= '0;
         idx_reg     <= '0;
         bit_cnt_reg <= '0;
         rem_reg     <= '0;
         dvd_reg     <= '0;
         quo_reg     <= '0;
      end else if (accept) begin
         det_reg     <= i_det;
         num_reg[0]  <= i_det_t;
         num_reg[1]  <= i_det_u;
         num_reg[2]  <= i_det_v;
         idx_reg     <= '0;
         bit_cnt_reg <= '0;
         rem_reg     <= '0;
         dvd_reg     <= mag_shift(i_det_t);
         quo_reg     <= '0;
      end else if (state_reg == DIV) begin
         if (bit_last) begin
            idx_reg     <= idx_reg + 2'd1;
            bit_cnt_reg <= '0;
            rem_reg     <= '0;
            dvd_reg     <= mag_shift(nxt_num);
            quo_reg     <= '0;
         end else begin
            bit_cnt_reg <= bit_cnt_reg + CW'(1);
            rem_reg     <= rem_nx;
            dvd_reg     <= {dvd_reg[W-2:0], 1'b0};
            quo_reg     <= quo_nx[W-2:0];
         end
      end
   end

   // One holding register per quotient, written when its division finishes.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_slot
         logic [31:0] slot_reg;
         // Cleared on every accept so a zero determinant yields zero quotients.
         always_ff @(posedge i_clk) begin
            if (i_rst || accept)
               slot_reg <= '0;
            else if (state_reg == DIV && bit_last && idx_reg == 2'(gi))
               slot_reg <= q_fin;
         end
         assign q_all[gi] = slot_reg;
      end
   endgenerate

   // Hit test on the final 32-bit quotients; u+v kept in 33 bits.
   always_comb begin
      logic signed [32:0] uv_sum;
      uv_sum = $signed({q_all[1][31], q_all[1]}) + $signed({q_all[2][31], q_all[2]});
      hit    = (det_reg != 32'd0) && ($signed(q_all[0]) > 32'sd0) &&
               !q_all[1][31] && !q_all[2][31] && (uv_sum <= ONE_Q);
   end

   // Result registers: only updated on the CHK->DONE edge, held otherwise.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_t   <= '0;
         o_u   <= '0;
         o_v   <= '0;
         o_hit <= 1'b0;
      end else if (state_reg == CHK) begin
         o_t   <= q_all[0];
         o_u   <= q_all[1];
         o_v   <= q_all[2];
         o_hit <= hit;
      end
   end

endmodule

// File: tb/tb_fip_32_cramer_div.sv
// tb_fip_32_cramer_div -- self-checking bench for fip_32_cramer_div.
// Fixed vector table, hand-written hold/reset sequences, and random sets
// checked against an arithmetic reference model (64-bit integer division).
// Latency is counted in rising edges with the accepting edge counted as 1.
module tb_fip_32_cramer_div;
   localparam int FRA = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_det, i_det_t, i_det_u, i_det_v;
   logic [31:0] o_t, o_u, o_v;
   logic        o_hit;
   logic        o_valid;
   logic        i_ready;

   int tests  = 0;
   int failed = 0;

   fip_32_cramer_div #(.FRA_BITS(FRA)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_det   (i_det),
      .i_det_t (i_det_t),
      .i_det_u (i_det_u),
      .i_det_v (i_det_v),
      .o_t     (o_t),
      .o_u     (o_u),
      .o_v     (o_v),
      .o_hit   (o_hit),
      .o_valid (o_valid),
      .i_ready (i_ready)
   );

   always #5 clk = ~clk;

`ifdef FIP_CRAMER_SAT_EN
   localparam logic [31:0] OVF_T = 32'h7fff_ffff;
   localparam logic        OVF_H = 1'b1;
`else
   localparam logic [31:0] OVF_T = 32'hffff_0000;
   localparam logic        OVF_H = 1'b0;
`endif

   typedef struct {
      logic [31:0] det, t, u, v;
      logic [31:0] et, eu, ev;
      logic        eh;
      int          lat;
   } vec_t;

   vec_t vecs [8];

   // Reference quotient: (num * 2^FRA) / den, truncated toward zero.
   function automatic logic [31:0] ref_q(input logic [31:0] num, input logic [31:0] den);
      longint n, d, q;
      if (den == 32'd0) return 32'd0;
      n = longint'($signed(num)) * (longint'(1) << FRA);
      d = longint'($signed(den));
      q = n / d;
`ifdef FIP_CRAMER_SAT_EN
      if (q > 64'sd2147483647) q = 64'sd2147483647;
      else if (q < -64'sd2147483648) q = -64'sd2147483648;
`endif
      return q[31:0];
   endfunction

   function automatic logic ref_hit(input logic [31:0] det, qt, qu, qv);
      longint s;
      s = longint'($signed(qu)) + longint'($signed(qv));
      return (det != 32'd0) && ($signed(qt) > 0) && ($signed(qu) >= 0) &&
             ($signed(qv) >= 0) && (s <= (longint'(1) << FRA));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else begin
         $display("[TB] ok   %s: 0x%08h", name, act);
      end
   endtask

   task automatic scramble();
      i_det   = $urandom;
      i_det_t = $urandom;
      i_det_u = $urandom;
      i_det_v = $urandom;
   endtask

   // Wait for o_ready, present one set, leave inputs scrambled after accept.
   task automatic send(input logic [31:0] d, t, u, v);
      int w = 0;
      while (!o_ready && w < 400) begin
         @(posedge clk); @(negedge clk); w++;
      end
      if (!o_ready) begin
         tests++; failed++;
         $display("[TB] FAIL ready_timeout: got o_ready=0 expected 1 within 400 cycles");
      end
      i_det = d; i_det_t = t; i_det_u = u; i_det_v = v;
      i_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      i_valid = 1'b0;
      scramble();
   endtask

   // Called at the negedge right after the accepting edge.
   task automatic collect(input string tag, input logic [31:0] et, eu, ev,
                          input logic eh, input int lat, input bit rel);
      int edges = 1;
      while (!o_valid && edges < 400) begin
         @(posedge clk); edges++; @(negedge clk);
      end
      $display("[TB] set %s: lat=%0d t=%08h u=%08h v=%08h hit=%0b", tag, edges, o_t, o_u, o_v, o_hit);
      chk({tag, ".latency"}, 32'(edges), 32'(lat));
      chk({tag, ".t"}, o_t, et);
      chk({tag, ".u"}, o_u, eu);
      chk({tag, ".v"}, o_v, ev);
      chk({tag, ".hit"}, {31'd0, o_hit}, {31'd0, eh});
      if (rel) begin
         i_ready = 1'b1;
         @(posedge clk); @(negedge clk);
         i_ready = 1'b0;
         chk({tag, ".ready_after"}, {31'd0, o_ready}, 32'd1);
      end
   endtask

   initial begin
      logic [31:0] d, t, u, v, qt, qu, qv;
      logic        seen;

      vecs[0] = '{32'h0002_0000, 32'h0001_0000, 32'h0000_8000, 32'h0000_8000,
                  32'h0000_8000, 32'h0000_4000, 32'h0000_4000, 1'b1, 146};
      vecs[1] = '{32'hFFFE_0000, 32'hFFFF_0000, 32'h0000_8000, 32'hFFFF_8000,
                  32'h0000_8000, 32'hFFFF_C000, 32'h0000_4000, 1'b0, 146};
      vecs[2] = '{32'h0000_0000, 32'h1234_5678, 32'h0001_0000, 32'hFFFF_0000,
                  32'h0, 32'h0, 32'h0, 1'b0, 2};
      vecs[3] = '{32'h0000_0001, 32'h7FFF_FFFF, 32'h0, 32'h0,
                  OVF_T, 32'h0, 32'h0, OVF_H, 146};
      vecs[4] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_8000, 32'h0000_8000,
                  32'h0001_0000, 32'h0000_8000, 32'h0000_8000, 1'b1, 146};
      vecs[5] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_8000, 32'h0000_8001,
                  32'h0001_0000, 32'h0000_8000, 32'h0000_8001, 1'b0, 146};
      vecs[6] = '{32'h0001_0000, 32'h0, 32'h0, 32'h0,
                  32'h0, 32'h0, 32'h0, 1'b0, 146};
      vecs[7] = '{32'h0003_0000, 32'hFFFF_0000, 32'h0001_0000, 32'h0,
                  32'hFFFF_AAAB, 32'h0000_5555, 32'h0, 1'b0, 146};

      rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
      scramble();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset.ready", {31'd0, o_ready}, 32'd1);
      chk("reset.valid", {31'd0, o_valid}, 32'd0);
      chk("reset.t", o_t, 32'd0);
      chk("reset.hit", {31'd0, o_hit}, 32'd0);

      // Fixed table.
      for (int i = 0; i < 8; i++) begin
         send(vecs[i].det, vecs[i].t, vecs[i].u, vecs[i].v);
         collect($sformatf("vec%0d", i), vecs[i].et, vecs[i].eu, vecs[i].ev,
                 vecs[i].eh, vecs[i].lat, 1'b1);
      end

      // Result held under back-pressure while new sets are offered.
      send(vecs[1].det, vecs[1].t, vecs[1].u, vecs[1].v);
      collect("hold", vecs[1].et, vecs[1].eu, vecs[1].ev, vecs[1].eh, 146, 1'b0);
      for (int c = 0; c < 10; c++) begin
         scramble();
         i_valid = 1'b1;
         @(posedge clk); @(negedge clk);
         chk($sformatf("hold%0d.ready", c), {31'd0, o_ready}, 32'd0);
         chk($sformatf("hold%0d.u", c), o_u, vecs[1].eu);
      end
      chk("hold.v", o_v, vecs[1].ev);
      chk("hold.valid", {31'd0, o_valid}, 32'd1);
      i_det = vecs[4].det; i_det_t = vecs[4].t; i_det_u = vecs[4].u; i_det_v = vecs[4].v;
      i_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      i_ready = 1'b0;
      chk("release.ready", {31'd0, o_ready}, 32'd1);
      chk("release.valid", {31'd0, o_valid}, 32'd0);
      @(posedge clk); @(negedge clk);
      i_valid = 1'b0;
      scramble();
      collect("after_hold", vecs[4].et, vecs[4].eu, vecs[4].ev, vecs[4].eh, 146, 1'b1);

      // Randomized sets against the reference model.
      for (int r = 0; r < 24; r++) begin
         d = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 20));
         if ($urandom_range(0, 1) == 1) d = -d;
         t = $urandom >> $urandom_range(0, 24);
         u = $urandom >> $urandom_range(0, 24);
         v = $urandom >> $urandom_range(0, 24);
         if ($urandom_range(0, 1) == 1) t = -t;
         if ($urandom_range(0, 3) == 0) u = -u;
         if ($urandom_range(0, 3) == 0) v = -v;
         qt = ref_q(t, d); qu = ref_q(u, d); qv = ref_q(v, d);
         send(d, t, u, v);
         collect($sformatf("rnd%0d", r), qt, qu, qv, ref_hit(d, qt, qu, qv),
                 (d == 32'd0) ? 2 : 146, 1'b1);
      end

      // Reset 50 cycles into a division: no result, outputs cleared.
      send(32'h0002_0000, 32'h0001_0000, 32'h0000_8000, 32'h0000_8000);
      repeat (49) begin @(posedge clk); @(negedge clk); end
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      chk("abort.ready", {31'd0, o_ready}, 32'd1);
      chk("abort.valid", {31'd0, o_valid}, 32'd0);
      chk("abort.t", o_t, 32'd0);
      chk("abort.u", o_u, 32'd0);
      chk("abort.v", o_v, 32'd0);
      chk("abort.hit", {31'd0, o_hit}, 32'd0);
      seen = 1'b0;
      repeat (200) begin
         @(posedge clk); @(negedge clk);
         if (o_valid) seen = 1'b1;
      end
      chk("abort.no_valid", {31'd0, seen}, 32'd0);

      // Reset wins over a simultaneous accept (det=0 would finish in 2 edges).
      i_det = 32'd0; i_det_t = 32'h0001_0000; i_det_u = 32'd0; i_det_v = 32'd0;
      i_valid = 1'b1; rst = 1'b1;
      @(posedge clk); @(negedge clk);
      i_valid = 1'b0; rst = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         if (o_valid || !o_ready) seen = 1'b1;
         @(posedge clk); @(negedge clk);
      end
      chk("rst_vs_accept", {31'd0, seen}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
